// File: rtl/rtc_alarm_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module : rtc_alarm_pkg
// Brief  : Shared types for the RTC alarm bank: scan states, mask bit
//          positions and the stored alarm entry.
// Rev    : 1.0
// ============================================================================
package rtc_alarm_pkg;

    // Entry value fields are sized for the widest supported TIME_W (16).
    localparam int MAX_TIME_W = 16;

    localparam int MASK_SEC  = 0;
    localparam int MASK_MIN  = 1;
    localparam int MASK_HOUR = 2;
    localparam int MASK_DAY  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [MAX_TIME_W-1:0] sec;
        logic [MAX_TIME_W-1:0] min;
        logic [MAX_TIME_W-1:0] hour;
        logic [MAX_TIME_W-1:0] day;
        logic [3:0]            mask;
        logic                  repeat_en;
        logic                  irq_en;
    } alarm_entry_t;

endpackage
`default_nettype wire

// File: rtl/rtc_alarm_bank_match.sv
`default_nettype none
// ============================================================================
// Module : rtc_alarm_match
// Brief  : Shared combinational comparator: hit when every enabled field of
//          the selected entry equals the snapshot (an empty mask never hits).
//          Day compare exists only with RTC_ALARM_DAY_MATCH_EN.
// Rev    : 1.0
// ============================================================================
module rtc_alarm_match
    import rtc_alarm_pkg::*;
#(
    parameter int TIME_W = 8
) (
    input  alarm_entry_t      entry,
    input  logic [TIME_W-1:0] snap_sec,
    input  logic [TIME_W-1:0] snap_min,
    input  logic [TIME_W-1:0] snap_hour,
`ifdef RTC_ALARM_DAY_MATCH_EN
    input  logic [TIME_W-1:0] snap_day,
`endif
    output logic              hit
);

    logic [3:0] w_eq;
    logic [3:0] w_mask;
    logic       w_unused_ctrl;

    assign w_eq[MASK_SEC]  = (entry.sec  == MAX_TIME_W'(snap_sec));
    assign w_eq[MASK_MIN]  = (entry.min  == MAX_TIME_W'(snap_min));
    assign w_eq[MASK_HOUR] = (entry.hour == MAX_TIME_W'(snap_hour));

`ifdef RTC_ALARM_DAY_MATCH_EN
    assign w_eq[MASK_DAY]  = (entry.day == MAX_TIME_W'(snap_day));
    assign w_mask          = entry.mask;
`else
    logic w_unused_day;
    assign w_eq[MASK_DAY]  = 1'b0;
    assign w_mask          = {1'b0, entry.mask[MASK_HOUR:MASK_SEC]};
    assign w_unused_day    = ^{entry.day, entry.mask[MASK_DAY]};
`endif

    assign w_unused_ctrl = ^{entry.repeat_en, entry.irq_en};

    assign hit = (|w_mask) && (&(w_eq | ~w_mask));

endmodule
`default_nettype wire

// File: rtl/rtc_alarm_bank.sv
`default_nettype none
// ============================================================================
// Module : rtc_alarm_bank
// Brief  : NUM_ALARMS-channel alarm engine; each sec_tick snapshots the time
//          and scans every alarm through one shared comparator, raising sticky
//          flags and an aggregated interrupt. Optional day match is enabled by
//          defining RTC_ALARM_DAY_MATCH_EN.
// Rev    : 1.0
// ============================================================================
module rtc_alarm_bank
    import rtc_alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int TIME_W     = 8,
    parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  sec_tick,
    input  logic [TIME_W-1:0]     time_sec,
    input  logic [TIME_W-1:0]     time_min,
    input  logic [TIME_W-1:0]     time_hour,
    input  logic [TIME_W-1:0]     time_day,
    input  logic                  cfg_wr,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [TIME_W-1:0]     cfg_sec,
    input  logic [TIME_W-1:0]     cfg_min,
    input  logic [TIME_W-1:0]     cfg_hour,
    input  logic [TIME_W-1:0]     cfg_day,
    input  logic [3:0]            cfg_mask,
    input  logic                  cfg_repeat,
    input  logic                  cfg_arm,
    input  logic                  cfg_irq_en,
    input  logic [NUM_ALARMS-1:0] clr_flags,
    input  logic                  clr_overrun,
    output logic [NUM_ALARMS-1:0] alarm_flag,
    output logic [NUM_ALARMS-1:0] alarm_armed,
    output logic                  alarm_irq,
    output logic                  busy,
    output logic                  scan_done,
    output logic                  scan_overrun
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_ALARMS - 1);

    scan_state_t           r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [TIME_W-1:0]     r_snap_sec;
    logic [TIME_W-1:0]     r_snap_min;
    logic [TIME_W-1:0]     r_snap_hour;
`ifdef RTC_ALARM_DAY_MATCH_EN
    logic [TIME_W-1:0]     r_snap_day;
`else
    logic                  w_unused_day;
    assign w_unused_day = ^{cfg_day, time_day};
`endif
    alarm_entry_t          r_entry [NUM_ALARMS];

    alarm_entry_t          w_new_entry;
    alarm_entry_t          w_sel_entry;
    logic [NUM_ALARMS-1:0] w_wr_sel;
    logic [NUM_ALARMS-1:0] w_irq_en;
    logic [NUM_ALARMS-1:0] w_fire_vec;
    logic [NUM_ALARMS-1:0] w_disarm;
    logic [NUM_ALARMS-1:0] w_flag_nxt;
    logic [NUM_ALARMS-1:0] w_armed_nxt;
    logic                  w_hit;
    logic                  w_fire;

    always_comb begin
        w_new_entry           = '0;
        w_new_entry.sec       = MAX_TIME_W'(cfg_sec);
        w_new_entry.min       = MAX_TIME_W'(cfg_min);
        w_new_entry.hour      = MAX_TIME_W'(cfg_hour);
        w_new_entry.mask      = cfg_mask;
        w_new_entry.repeat_en = cfg_repeat;
        w_new_entry.irq_en    = cfg_irq_en;
`ifdef RTC_ALARM_DAY_MATCH_EN
        w_new_entry.day       = MAX_TIME_W'(cfg_day);
`else
        w_new_entry.mask[MASK_DAY] = 1'b0;
`endif
    end

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_chan
        assign w_wr_sel[gi] = cfg_wr && (cfg_idx == IDX_W'(gi));
        assign w_irq_en[gi] = r_entry[gi].irq_en;
    end

    assign w_sel_entry = r_entry[r_idx];

    rtc_alarm_match #(
        .TIME_W    (TIME_W)
    ) u_match (
        .entry     (w_sel_entry),
        .snap_sec  (r_snap_sec),
        .snap_min  (r_snap_min),
        .snap_hour (r_snap_hour),
`ifdef RTC_ALARM_DAY_MATCH_EN
        .snap_day  (r_snap_day),
`endif
        .hit       (w_hit)
    );

    assign w_fire = (r_state == SCAN) && alarm_armed[r_idx] && w_hit;

    // A config write to a channel overrides both its flag set and one-shot disarm.
    always_comb begin
        w_fire_vec = '0;
        if (w_fire) begin
            w_fire_vec[r_idx] = 1'b1;
        end
        w_disarm    = w_fire_vec & ~{NUM_ALARMS{w_sel_entry.repeat_en}};
        w_flag_nxt  = ((alarm_flag & ~clr_flags) | w_fire_vec) & ~w_wr_sel;
        w_armed_nxt = (alarm_armed & ~w_disarm & ~w_wr_sel) |
                      (w_wr_sel & {NUM_ALARMS{cfg_arm}});
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_entry[i] <= '0;
            end
            alarm_flag  <= '0;
            alarm_armed <= '0;
            alarm_irq   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (w_wr_sel[i]) begin
                    r_entry[i] <= w_new_entry;
                end
            end
            alarm_flag  <= w_flag_nxt;
            alarm_armed <= w_armed_nxt;
            alarm_irq   <= |(alarm_flag & w_irq_en);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_snap_sec   <= '0;
            r_snap_min   <= '0;
            r_snap_hour  <= '0;
`ifdef RTC_ALARM_DAY_MATCH_EN
            r_snap_day   <= '0;
`endif
            busy         <= 1'b0;
            scan_done    <= 1'b0;
            scan_overrun <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (sec_tick && (r_state != IDLE)) begin
                scan_overrun <= 1'b1;
            end else if (clr_overrun) begin
                scan_overrun <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (sec_tick) begin
                        r_snap_sec  <= time_sec;
                        r_snap_min  <= time_min;
                        r_snap_hour <= time_hour;
`ifdef RTC_ALARM_DAY_MATCH_EN
                        r_snap_day  <= time_day;
`endif
                        r_idx       <= '0;
                        busy        <= 1'b1;
                        r_state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_idx == C_LAST_IDX) begin
                        scan_done <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtc_alarm_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_rtc_alarm_bank
// Brief  : Scoreboard bench for rtc_alarm_bank: directed timing cases plus
//          randomized config/clear/tick traffic against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_rtc_alarm_bank;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int IW = 2;
`ifdef RTC_ALARM_DAY_MATCH_EN
    localparam bit DAY_EN = 1'b1;
`else
    localparam bit DAY_EN = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          sec_tick = 1'b0;
    logic [TW-1:0] time_sec = '0, time_min = '0, time_hour = '0, time_day = '0;
    logic          cfg_wr = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [TW-1:0] cfg_sec = '0, cfg_min = '0, cfg_hour = '0, cfg_day = '0;
    logic [3:0]    cfg_mask = '0;
    logic          cfg_repeat = 1'b0, cfg_arm = 1'b0, cfg_irq_en = 1'b0;
    logic [N-1:0]  clr_flags = '0;
    logic          clr_overrun = 1'b0;
    logic [N-1:0]  alarm_flag, alarm_armed;
    logic          alarm_irq, busy, scan_done, scan_overrun;

    rtc_alarm_bank #(
        .NUM_ALARMS (N),
        .TIME_W     (TW),
        .IDX_W      (IW)
    ) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .sec_tick     (sec_tick),
        .time_sec     (time_sec),
        .time_min     (time_min),
        .time_hour    (time_hour),
        .time_day     (time_day),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_sec      (cfg_sec),
        .cfg_min      (cfg_min),
        .cfg_hour     (cfg_hour),
        .cfg_day      (cfg_day),
        .cfg_mask     (cfg_mask),
        .cfg_repeat   (cfg_repeat),
        .cfg_arm      (cfg_arm),
        .cfg_irq_en   (cfg_irq_en),
        .clr_flags    (clr_flags),
        .clr_overrun  (clr_overrun),
        .alarm_flag   (alarm_flag),
        .alarm_armed  (alarm_armed),
        .alarm_irq    (alarm_irq),
        .busy         (busy),
        .scan_done    (scan_done),
        .scan_overrun (scan_overrun)
    );

    always #5 pclk = ~pclk;

    // Reference model: alarm table as plain arrays of field values.
    int           m_val [N][4];
    logic [3:0]   m_mask [N];
    bit           m_rpt [N];
    logic [N-1:0] m_flag, m_armed, m_irqen;

    typedef struct {
        logic [N-1:0] flag;
        logic [N-1:0] armed;
        logic         irq;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void reset_model();
        for (int a = 0; a < N; a++) begin
            for (int f = 0; f < 4; f++) m_val[a][f] = 0;
            m_mask[a] = '0;
            m_rpt[a]  = 1'b0;
        end
        m_flag  = '0;
        m_armed = '0;
        m_irqen = '0;
    endfunction

    function automatic bit model_match(int a, int s, int mi, int h, int d);
        int  now[4];
        bit  any = 1'b0;
        bit  ok  = 1'b1;
        now = '{s, mi, h, d};
        for (int f = 0; f < 4; f++) begin
            if (m_mask[a][f] && (f != 3 || DAY_EN)) begin
                any = 1'b1;
                if (m_val[a][f] != now[f]) ok = 1'b0;
            end
        end
        return any && ok;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic cfg_write(int idx, int s, int mi, int h, int d,
                             logic [3:0] mask, bit rpt, bit arm, bit irqen);
        cfg_wr     = 1'b1;
        cfg_idx    = IW'(idx);
        cfg_sec    = TW'(s);
        cfg_min    = TW'(mi);
        cfg_hour   = TW'(h);
        cfg_day    = TW'(d);
        cfg_mask   = mask;
        cfg_repeat = rpt;
        cfg_arm    = arm;
        cfg_irq_en = irqen;
        m_val[idx] = '{s, mi, h, d};
        m_mask[idx]  = mask;
        m_rpt[idx]   = rpt;
        m_flag[idx]  = 1'b0;
        m_armed[idx] = arm;
        m_irqen[idx] = irqen;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic clear_flags(logic [N-1:0] m);
        clr_flags = m;
        m_flag    = m_flag & ~m;
        step();
        clr_flags = '0;
    endtask

    // Returns in cycle T+1; the live time inputs are scrambled during the scan.
    task automatic do_tick(int s, int mi, int h, int d);
        exp_t e;
        time_sec  = TW'(s);
        time_min  = TW'(mi);
        time_hour = TW'(h);
        time_day  = TW'(d);
        sec_tick  = 1'b1;
        for (int a = 0; a < N; a++) begin
            if (m_armed[a] && model_match(a, s, mi, h, d)) begin
                m_flag[a] = 1'b1;
                if (!m_rpt[a]) m_armed[a] = 1'b0;
            end
        end
        e.flag  = m_flag;
        e.armed = m_armed;
        e.irq   = |(m_flag & m_irqen);
        sb_q.push_back(e);
        step();
        sec_tick  = 1'b0;
        time_sec  = TW'($urandom);
        time_min  = TW'($urandom);
        time_hour = TW'($urandom);
        time_day  = TW'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge pclk);
            if (presetn === 1'b1 && scan_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done: scan_done=1 with no scan pending, required 0");
                end else begin
                    e = sb_q.pop_front();
                    check("sb_flag", alarm_flag, e.flag);
                    check("sb_armed", alarm_armed, e.armed);
                    @(negedge pclk);
                    check("sb_irq", alarm_irq, e.irq);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset_model();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_flag", alarm_flag, 0);
        check("rst_armed", alarm_armed, 0);
        check("rst_irq", alarm_irq, 0);
        check("rst_busy", busy, 0);
        check("rst_done", scan_done, 0);
        check("rst_overrun", scan_overrun, 0);
        presetn = 1'b1;
        step();

        // One-shot on seconds
        cfg_write(0, 'h30, 0, 0, 0, 4'b0001, 1'b0, 1'b1, 1'b1);
        check("cfg_armed_visible", alarm_armed, 4'b0001);
        do_tick('h30, 0, 0, 0);
        check("t1_flag_T1", alarm_flag, 0);
        check("t1_busy_T1", busy, 1);
        step();
        check("t1_flag_T2", alarm_flag, 4'b0001);
        check("t1_armed_T2", alarm_armed, 4'b0000);
        check("t1_irq_T2", alarm_irq, 0);
        step();
        check("t1_irq_T3", alarm_irq, 1);
        wait_idle();
        clear_flags(4'b0001);
        check("irq_lag", alarm_irq, 1);
        step();
        check("irq_drop", alarm_irq, 0);
        do_tick('h30, 0, 0, 0);
        wait_idle();
        check("t1_no_refire", alarm_flag, 0);

        // Repeat alarm on hour:min
        cfg_write(2, 0, 'h15, 'h07, 0, 4'b0110, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            do_tick(k, 'h15, 'h07, 0);
            step();
            step();
            check("t2_flag_T3", alarm_flag[2], 0);
            step();
            check("t2_flag_T4", alarm_flag[2], 1);
            check("t2_armed_T4", alarm_armed[2], 1);
            wait_idle();
            if (k == 0) clear_flags(4'b0100);
        end

        // Overrun: second tick at T+3
        do_tick(0, 0, 0, 0);
        step();
        step();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        check("ovr_set", scan_overrun, 1);
        check("ovr_done_T4", scan_done, 0);
        step();
        check("ovr_done_T5", scan_done, 1);
        step();
        check("ovr_busy_T6", busy, 0);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("ovr_clear", scan_overrun, 0);

        // Minimum legal spacing N+2 must not overrun
        do_tick(0, 0, 0, 0);
        repeat (N + 1) step();
        do_tick(0, 0, 0, 0);
        check("min_spacing_no_ovr", scan_overrun, 0);
        wait_idle();

        // clr_flags in the same cycle as the set: set wins
        cfg_write(1, 5, 0, 0, 0, 4'b0001, 1'b1, 1'b1, 1'b0);
        do_tick(5, 0, 0, 0);
        step();
        clr_flags = 4'b0010;
        step();
        clr_flags = '0;
        check("clr_vs_set", alarm_flag[1], 1);
        wait_idle();

        // cfg write to the channel under compare wins over set and disarm
        cfg_write(1, 5, 0, 0, 0, 4'b0001, 1'b0, 1'b1, 1'b1);
        do_tick(5, 0, 0, 0);
        step();
        cfg_write(1, 6, 0, 0, 0, 4'b0001, 1'b0, 1'b1, 1'b1);
        sb_q[sb_q.size()-1].flag  = m_flag;
        sb_q[sb_q.size()-1].armed = m_armed;
        sb_q[sb_q.size()-1].irq   = |(m_flag & m_irqen);
        check("wr_wins_flag", alarm_flag[1], 0);
        check("wr_wins_armed", alarm_armed[1], 1);
        wait_idle();

        // Empty mask never matches
        cfg_write(3, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            do_tick($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
            wait_idle();
        end
        check("mask0_no_flag", alarm_flag[3], 0);

        // Day field gating
        clear_flags('1);
        cfg_write(0, 'h10, 0, 0, 'h15, 4'b1001, 1'b1, 1'b1, 1'b1);
        do_tick('h10, 0, 0, 'h16);
        wait_idle();
        check("day_mismatch", alarm_flag[0], DAY_EN ? 0 : 1);
        do_tick('h10, 0, 0, 'h15);
        wait_idle();
        check("day_match", alarm_flag[0], 1);

        // Reset mid-scan
        do_tick(0, 'h15, 'h07, 0);
        step();
        presetn = 1'b0;
        #1;
        check("mrst_flag", alarm_flag, 0);
        check("mrst_armed", alarm_armed, 0);
        check("mrst_irq", alarm_irq, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", scan_done, 0);
        check("mrst_overrun", scan_overrun, 0);
        sb_q.delete();
        reset_model();
        step();
        presetn = 1'b1;
        repeat (N + 2) step();
        check("mrst_stays_idle", busy, 0);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: cfg_write($urandom_range(0, N - 1), $urandom_range(0, 2), $urandom_range(0, 2),
                             $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom_range(0, 15)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1: clear_flags(N'($urandom_range(0, 15)));
                default: begin
                    do_tick($urandom_range(0, 2), $urandom_range(0, 2),
                            $urandom_range(0, 2), $urandom_range(0, 2));
                    wait_idle();
                end
            endcase
            check("rand_flag", alarm_flag, m_flag);
            check("rand_armed", alarm_armed, m_armed);
        end

        wait_idle();
        repeat (3) step();
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
